// File: rtl/wb_gpio_debounce_if.sv
// Wishbone B3 classic bus bundle for the wb_gpio_debounce slave.
// The master modport belongs to the interconnect, the slave modport to the GPIO block.
interface wb_gpio_debounce_if;
    logic [4:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_gpio_debounce.sv
// Wishbone GPIO slave: registered outputs, synchronised and debounced inputs,
// per-input rising/falling edge flags with a masked level interrupt.
// Optional feature macro GPIO_PWM_EN: adds an 8-bit duty register that gates
// every output with a free-running 256-cycle PWM. Without it gpio_o = OUT.
//
// adr[4:2] | register
// 0        | OUT    RW
// 1        | IN     RO  debounced value
// 2        | MASK   RW
// 3        | STATUS W1C edge flags
// 4        | RISE   RW
// 5        | FALL   RW
// 6        | PWM    RW  (reads 0 without GPIO_PWM_EN)
// 7        | INFO   RO
module wb_gpio_debounce #(
    parameter int               N_OUT     = 8,
    parameter int               N_IN      = 6,
    parameter int               DB_CYCLES = 500000,
    parameter logic [N_OUT-1:0] OUT_RESET = '0
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    wb_gpio_debounce_if.slave   wb,
    input  logic [N_IN-1:0]     gpio_i,
    output logic [N_OUT-1:0]    gpio_o,
    output logic                irq_o
);

    localparam int               CNT_W   = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [N_OUT-1:0] out_reg;
    logic [N_IN-1:0]  mask, status, rise_en, fall_en;
    logic [N_IN-1:0]  sync1, sync2, stable;
    logic [CNT_W-1:0] cnt [N_IN];
    logic [N_IN-1:0]  upd, set_flags, w1c;
    logic             access, wr;
    logic [2:0]       reg_sel;
    logic [31:0]      rdata;
    logic             unused_bits;
`ifdef GPIO_PWM_EN
    logic [7:0]       pwm, pwm_cnt;
`endif

    // An access is serviced only when ack is low, so ack can never be two cycles wide.
    assign access  = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
    assign wr      = access & wb.wb_we_i;
    assign reg_sel = wb.wb_adr_i[4:2];
    assign w1c     = (wr && reg_sel == 3'd3) ? wb.wb_dat_i[N_IN-1:0] : '0;

    // Byte lanes and the low address bits carry no meaning for this slave.
    assign unused_bits = ^{wb.wb_sel_i, wb.wb_adr_i[1:0], wb.wb_dat_i};

    // A debounced bit flips on the cycle its counter reaches terminal count; flag the enabled edges.
    always_comb begin
        upd = '0;
        for (int i = 0; i < N_IN; i++)
            upd[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
        set_flags = upd & ((sync2 & rise_en) | (~sync2 & fall_en));
    end

    // Read data mux; unused upper bits stay zero.
    always_comb begin
        rdata = '0;
        case (reg_sel)
            3'd0: rdata[N_OUT-1:0] = out_reg;
            3'd1: rdata[N_IN-1:0]  = stable;
            3'd2: rdata[N_IN-1:0]  = mask;
            3'd3: rdata[N_IN-1:0]  = status;
            3'd4: rdata[N_IN-1:0]  = rise_en;
            3'd5: rdata[N_IN-1:0]  = fall_en;
`ifdef GPIO_PWM_EN
            3'd6: rdata[7:0]       = pwm;
`endif
            3'd7: rdata = {8'h00, 1'b1, 7'h00, 8'(N_IN), 8'(N_OUT)};
            default: rdata = '0;
        endcase
    end

    // Bus handshake and the plain RW registers; writes commit on the ack edge.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb.wb_ack_o <= 1'b0;
            wb.wb_dat_o <= '0;
            out_reg     <= OUT_RESET;
            mask        <= '0;
            rise_en     <= '0;
            fall_en     <= '0;
        end else begin
            wb.wb_ack_o <= access;
            wb.wb_dat_o <= access ? rdata : '0;
            if (wr) begin
                case (reg_sel)
                    3'd0:    out_reg <= wb.wb_dat_i[N_OUT-1:0];
                    3'd2:    mask    <= wb.wb_dat_i[N_IN-1:0];
                    3'd4:    rise_en <= wb.wb_dat_i[N_IN-1:0];
                    3'd5:    fall_en <= wb.wb_dat_i[N_IN-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Two-flop synchroniser followed by a per-bit hold counter; any return to STABLE restarts the count.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            for (int i = 0; i < N_IN; i++) cnt[i] <= '0;
        end else begin
            sync1 <= gpio_i;
            sync2 <= sync1;
            for (int i = 0; i < N_IN; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Edge flags: a new edge beats a simultaneous W1C; irq follows the masked flags one cycle later.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            status <= '0;
            irq_o  <= 1'b0;
        end else begin
            status <= (status & ~w1c) | set_flags;
            irq_o  <= |(status & mask);
        end
    end

`ifdef GPIO_PWM_EN
    // Output stage gated by the duty compare; PWM=0xFF leaves one dark cycle in 256.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pwm     <= 8'hFF;
            pwm_cnt <= 8'h00;
            gpio_o  <= OUT_RESET;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            if (wr && reg_sel == 3'd6) pwm <= wb.wb_dat_i[7:0];
            gpio_o <= out_reg & {N_OUT{pwm_cnt < pwm}};
        end
    end
`else
    // Output stage: a plain register copy of OUT.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) gpio_o <= OUT_RESET;
        else          gpio_o <= out_reg;
    end
`endif

endmodule

// File: tb/tb_wb_gpio_debounce.sv
// Directed bench for wb_gpio_debounce with DB_CYCLES=16 and OUT_RESET=8'h3C.
// The PWM scenario is compiled in only when GPIO_PWM_EN is defined.
module tb_wb_gpio_debounce;

    localparam int N_OUT = 8;
    localparam int N_IN  = 6;
    localparam int DB    = 16;

    localparam logic [4:0] A_OUT    = 5'h00;
    localparam logic [4:0] A_IN     = 5'h04;
    localparam logic [4:0] A_MASK   = 5'h08;
    localparam logic [4:0] A_STATUS = 5'h0C;
    localparam logic [4:0] A_RISE   = 5'h10;
    localparam logic [4:0] A_FALL   = 5'h14;
    localparam logic [4:0] A_PWM    = 5'h18;
    localparam logic [4:0] A_INFO   = 5'h1C;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N_IN-1:0]  gpio_i = '0;
    logic [N_OUT-1:0] gpio_o;
    logic             irq;

    int total = 0;
    int bad   = 0;

    wb_gpio_debounce_if bus ();

    wb_gpio_debounce #(
        .N_OUT(N_OUT), .N_IN(N_IN), .DB_CYCLES(DB), .OUT_RESET(8'h3C)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .wb(bus),
        .gpio_i(gpio_i),
        .gpio_o(gpio_o),
        .irq_o(irq)
    );

    always #5 clk = ~clk;

    // Starts right after a clock edge; returns #1 after the ack edge with the bus idle.
    task automatic wb_xfer(input logic we, input logic [4:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat, output int cyc_n);
        bit done;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = wdat;
        rdat  = '0;
        cyc_n = 0;
        done  = 1'b0;
        while (!done && cyc_n < 8) begin
            @(posedge clk); #1;
            cyc_n++;
            if (bus.wb_ack_o) begin
                rdat = bus.wb_dat_o;
                done = 1'b1;
            end
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL bus_timeout adr=%h: no ack within %0d cycles", adr, cyc_n);
        end
    endtask

    task automatic wb_write(input logic [4:0] adr, input logic [31:0] wdat);
        logic [31:0] d;
        int n;
        wb_xfer(1'b1, adr, wdat, d, n);
    endtask

    task automatic wb_read(input logic [4:0] adr, output logic [31:0] rdat);
        int n;
        wb_xfer(1'b0, adr, 32'h0, rdat, n);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (gpio_o !== 8'h3C || bus.wb_ack_o !== 1'b0 || bus.wb_dat_o !== 32'h0 || irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got gpio=%h ack=%b dat=%h irq=%b, want 3c 0 0 0",
                     gpio_o, bus.wb_ack_o, bus.wb_dat_o, irq);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        wb_read(A_INFO, d);
        total++;
        if (d !== 32'h0080_0608) begin
            bad++;
            $display("FAIL info: got %h want 00800608", d);
        end
        wb_read(A_STATUS, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL reset_status: got %h want 0", d);
        end
    endtask

    task automatic test_write_out();
        logic [31:0] d;
        int n;
        @(posedge clk); #1;
        wb_xfer(1'b1, A_OUT, 32'h0000_00A5, d, n);
        total++;
        if (n !== 1) begin
            bad++;
            $display("FAIL write_ack_latency: got %0d cycles want 1", n);
        end
        total++;
        if (gpio_o !== 8'h3C) begin
            bad++;
            $display("FAIL gpio_before_update: got %h want 3c", gpio_o);
        end
        @(posedge clk); #1;
        total++;
        if (gpio_o !== 8'hA5) begin
            bad++;
            $display("FAIL gpio_after_write: got %h want a5", gpio_o);
        end
        wb_read(A_OUT, d);
        total++;
        if (d !== 32'h0000_00A5) begin
            bad++;
            $display("FAIL read_out: got %h want 000000a5", d);
        end
        wb_write(A_OUT, 32'hFFFF_FF5A);
        wb_read(A_OUT, d);
        total++;
        if (d !== 32'h0000_005A) begin
            bad++;
            $display("FAIL out_upper_bits: got %h want 0000005a", d);
        end
    endtask

    task automatic test_debounce();
        logic [31:0] d;
        int highs;
        int first;
        wb_write(A_RISE, 32'h1);
        wb_write(A_MASK, 32'h1);
        gpio_i[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        gpio_i[0] = 1'b0;
        highs = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (irq) highs++;
        end
        total++;
        if (highs !== 0) begin
            bad++;
            $display("FAIL glitch_irq: irq high %0d cycles want 0", highs);
        end
        wb_read(A_IN, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL glitch_in: got %h want 0", d);
        end
        wb_read(A_STATUS, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL glitch_status: got %h want 0", d);
        end
        // STABLE changes 18 edges after the pin, irq one edge later.
        gpio_i[0] = 1'b1;
        first = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (irq && first == 0) first = k;
        end
        total++;
        if (first !== 19) begin
            bad++;
            $display("FAIL debounce_latency: irq at edge %0d want 19", first);
        end
        wb_read(A_IN, d);
        total++;
        if (d !== 32'h1) begin
            bad++;
            $display("FAIL debounced_in: got %h want 1", d);
        end
        wb_read(A_STATUS, d);
        total++;
        if (d !== 32'h1) begin
            bad++;
            $display("FAIL rise_status: got %h want 1", d);
        end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        int n;
        wb_write(A_STATUS, 32'h0);
        wb_read(A_STATUS, d);
        total++;
        if (d !== 32'h1 || irq !== 1'b1) begin
            bad++;
            $display("FAIL w0_keeps: got status=%h irq=%b want 1 1", d, irq);
        end
        wb_write(A_STATUS, 32'h1);
        @(posedge clk); #1;
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL w1c_irq: got %b want 0", irq);
        end
        wb_write(A_FALL, 32'h1);
        gpio_i[0] = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL fall_irq: got %b want 1", irq);
        end
        wb_write(A_MASK, 32'h0);
        @(posedge clk); #1;
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL mask_clear_irq: got %b want 0", irq);
        end
        wb_read(A_STATUS, d);
        total++;
        if (d !== 32'h1) begin
            bad++;
            $display("FAIL status_after_mask: got %h want 1", d);
        end
        wb_write(A_STATUS, 32'h1);
        wb_read(A_STATUS, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL status_cleared: got %h want 0", d);
        end
        // Land the W1C ack edge on the 18th edge after the pin rises.
        gpio_i[0] = 1'b1;
        repeat (17) @(posedge clk);
        #1;
        wb_xfer(1'b1, A_STATUS, 32'h1, d, n);
        total++;
        if (n !== 1) begin
            bad++;
            $display("FAIL collide_ack: got %0d cycles want 1", n);
        end
        wb_read(A_STATUS, d);
        total++;
        if (d !== 32'h1) begin
            bad++;
            $display("FAIL set_beats_w1c: got %h want 1", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  pat;
        logic [31:0] dat1;
        logic [31:0] d;
        @(posedge clk); #1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 5'h1F;
        pat[3] = bus.wb_ack_o;
        dat1 = '0;
        for (int k = 2; k >= 0; k--) begin
            @(posedge clk); #1;
            pat[k] = bus.wb_ack_o;
            if (k == 2) dat1 = bus.wb_dat_o;
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        total++;
        if (pat !== 4'b0101) begin
            bad++;
            $display("FAIL ack_pattern: got %b want 0101", pat);
        end
        total++;
        if (dat1 !== 32'h0080_0608) begin
            bad++;
            $display("FAIL adr_1f_info: got %h want 00800608", dat1);
        end
        @(posedge clk); #1;
`ifndef GPIO_PWM_EN
        wb_write(A_PWM, 32'h40);
        wb_read(A_PWM, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL pwm_absent: got %h want 0", d);
        end
`else
        wb_read(A_PWM, d);
        total++;
        if (d !== 32'hFF) begin
            bad++;
            $display("FAIL pwm_reset: got %h want ff", d);
        end
`endif
    endtask

`ifdef GPIO_PWM_EN
    task automatic test_pwm();
        int on;
        int odd;
        wb_write(A_OUT, 32'hFF);
        wb_write(A_PWM, 32'd64);
        @(posedge clk); #1;
        on = 0;
        odd = 0;
        for (int k = 0; k < 256; k++) begin
            @(posedge clk); #1;
            if (gpio_o == 8'hFF) on++;
            else if (gpio_o != 8'h00) odd++;
        end
        total++;
        if (on !== 64 || odd !== 0) begin
            bad++;
            $display("FAIL pwm_64: high %0d mixed %0d want 64 0", on, odd);
        end
        wb_write(A_PWM, 32'd0);
        @(posedge clk); #1;
        on = 0;
        for (int k = 0; k < 256; k++) begin
            @(posedge clk); #1;
            if (gpio_o != 8'h00) on++;
        end
        total++;
        if (on !== 0) begin
            bad++;
            $display("FAIL pwm_0: nonzero %0d cycles want 0", on);
        end
    endtask
`endif

    task automatic test_reset_mid_cycle();
        @(posedge clk); #1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = A_INFO;
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.wb_ack_o !== 1'b0 || gpio_o !== 8'h3C) begin
            bad++;
            $display("FAIL reset_mid: got ack=%b gpio=%h want 0 3c", bus.wb_ack_o, gpio_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (bus.wb_ack_o !== 1'b1 || bus.wb_dat_o !== 32'h0080_0608) begin
            bad++;
            $display("FAIL restart_ack: got ack=%b dat=%h want 1 00800608",
                     bus.wb_ack_o, bus.wb_dat_o);
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = '0;
        bus.wb_dat_i = '0;
        bus.wb_sel_i = 4'hF;
        test_reset();
        test_write_out();
        test_debounce();
        test_irq();
        test_back_to_back();
`ifdef GPIO_PWM_EN
        test_pwm();
`endif
        test_reset_mid_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
